// File: rtl/simon_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : simon_cipher_core
// Description : Parametrised SIMON block-cipher engine. The key schedule is
//               expanded once per key load into a register array and reused
//               for any number of encrypt/decrypt blocks, one round per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_cipher_core #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [N*M-1:0]   key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [2*N-1:0]   in_block,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_block,
    output logic             out_mode,
    output logic             key_loaded,
    output logic             busy
);

    // Index of the (N,M) pair in the table of legal configurations, -1 if illegal.
    function automatic int pair_index(input int n, input int m);
        if (n == 16 && m == 4) return 0;
        if (n == 24 && m == 3) return 1;
        if (n == 24 && m == 4) return 2;
        if (n == 32 && m == 3) return 3;
        if (n == 32 && m == 4) return 4;
        if (n == 48 && m == 2) return 5;
        if (n == 48 && m == 3) return 6;
        if (n == 64 && m == 2) return 7;
        if (n == 64 && m == 3) return 8;
        if (n == 64 && m == 4) return 9;
        return -1;
    endfunction

    function automatic int rounds_of(input int p);
        case (p)
            0: return 32;
            1: return 36;
            2: return 36;
            3: return 42;
            4: return 44;
            5: return 52;
            6: return 54;
            7: return 68;
            8: return 69;
            9: return 72;
            default: return 32;
        endcase
    endfunction

    // Published z sequences, written left-to-right so that z[i] is bit 61-i.
    localparam logic [61:0] c_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] c_Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] c_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] c_Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] c_Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic logic [61:0] z_of(input int p);
        case (p)
            0, 1:    return c_Z0;
            2:       return c_Z1;
            3, 5, 7: return c_Z2;
            4, 6, 8: return c_Z3;
            9:       return c_Z4;
            default: return c_Z0;
        endcase
    endfunction

    localparam int          c_PIDX = pair_index(N, M);
    localparam int          c_T    = rounds_of(c_PIDX);
    localparam int          c_KW   = $clog2(c_T);
    localparam logic [61:0] c_Z    = z_of(c_PIDX);

    if (c_PIDX < 0) begin : g_bad_pair
        $fatal(1, "simon_cipher_core: illegal (N,M) pair");
    end

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int a);
        return (v << a) | (v >> (N - a));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int a);
        return rotl(v, N - a);
    endfunction

    function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    typedef enum logic [2:0] {
        S_NOKEY  = 3'd0,
        S_EXPAND = 3'd1,
        S_IDLE   = 3'd2,
        S_RUN    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_ks [0:c_T-1];
    logic [N-1:0]    r_sr [0:M-1];
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_y;
    logic            r_mode;
    logic            r_key_loaded;
    logic [6:0]      r_cnt;

    logic            w_last;
    logic            w_key_hs;
    logic            w_in_hs;
    logic [5:0]      w_zidx;
    logic            w_zbit;
    logic [N-1:0]    w_kx_a;
    logic [N-1:0]    w_kx_b;
    logic [N-1:0]    w_kx_new;
    logic [c_KW-1:0] w_ridx;
    logic [N-1:0]    w_rk;
    logic [N-1:0]    w_nx;
    logic [N-1:0]    w_ny;

    assign w_last   = (r_cnt == 7'(c_T - 1));
    assign w_key_hs = key_valid && key_ready;
    assign w_in_hs  = in_valid && in_ready;
    assign w_zidx   = (r_cnt >= 7'd62) ? 6'(r_cnt - 7'd62) : r_cnt[5:0];
    assign w_zbit   = c_Z[6'd61 - w_zidx];

    // Next key word from the shift register holding k[i] .. k[i+M-1].
    always_comb begin
        w_kx_a = rotr(r_sr[M-1], 3);
        if (M == 4) begin
            w_kx_a = w_kx_a ^ r_sr[1];
        end
        w_kx_b   = w_kx_a ^ rotr(w_kx_a, 1);
        w_kx_new = ~r_sr[0] ^ w_kx_b ^ {{(N-1){1'b0}}, w_zbit} ^ {{(N-2){1'b0}}, 2'b11};
    end

    // One Feistel round; decryption walks the schedule backwards.
    always_comb begin
        w_ridx = r_mode ? c_KW'(7'(c_T - 1) - r_cnt) : r_cnt[c_KW-1:0];
        w_rk   = r_ks[w_ridx];
        if (r_mode) begin
            w_nx = r_y;
            w_ny = r_x ^ simon_f(r_y) ^ w_rk;
        end else begin
            w_nx = r_y ^ simon_f(r_x) ^ w_rk;
            w_ny = r_x;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_NOKEY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs; key offers win over block offers.
    always_comb begin
        w_state_nxt = r_state;
        key_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) w_state_nxt = S_EXPAND;
            end
            S_EXPAND: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                key_ready = 1'b1;
                in_ready  = !key_valid;
                if (key_valid)     w_state_nxt = S_EXPAND;
                else if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_NOKEY;
        endcase
    end

    // Block state, mode, shared counter and key-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_mode       <= 1'b0;
            r_cnt        <= '0;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_NOKEY, S_IDLE: begin
                    if (w_key_hs) begin
                        r_cnt        <= '0;
                        r_key_loaded <= 1'b0;
                    end else if (w_in_hs) begin
                        r_x    <= in_block[2*N-1:N];
                        r_y    <= in_block[N-1:0];
                        r_mode <= in_mode;
                        r_cnt  <= '0;
                    end
                end
                S_EXPAND: begin
                    r_cnt <= w_last ? 7'd0 : r_cnt + 7'd1;
                    if (w_last) r_key_loaded <= 1'b1;
                end
                S_RUN: begin
                    r_x   <= w_nx;
                    r_y   <= w_ny;
                    r_cnt <= w_last ? 7'd0 : r_cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

    // Key shift register and schedule array; contents are don't-care until expanded.
    always_ff @(posedge clk) begin
        if (w_key_hs) begin
            for (int j = 0; j < M; j++) begin
                r_sr[j] <= key[j*N +: N];
            end
        end else if (r_state == S_EXPAND) begin
            r_ks[r_cnt[c_KW-1:0]] <= r_sr[0];
            for (int j = 0; j < M - 1; j++) begin
                r_sr[j] <= r_sr[j+1];
            end
            r_sr[M-1] <= w_kx_new;
        end
    end

    assign out_block  = {r_x, r_y};
    assign out_mode   = r_mode;
    assign key_loaded = r_key_loaded;

endmodule
`default_nettype wire

// File: tb/tb_simon_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_cipher_core
// Description : Directed self-checking bench for simon_cipher_core using the
//               published SIMON32/64 and SIMON64/128 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_cipher_core;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // SIMON32/64 instance
    logic        a_key_valid, a_key_ready, a_in_valid, a_in_ready, a_in_mode;
    logic        a_out_valid, a_out_ready, a_out_mode, a_key_loaded, a_busy;
    logic [63:0] a_key;
    logic [31:0] a_in_block, a_out_block;

    // SIMON64/128 instance
    logic         b_key_valid, b_key_ready, b_in_valid, b_in_ready, b_in_mode;
    logic         b_out_valid, b_out_ready, b_out_mode, b_key_loaded, b_busy;
    logic [127:0] b_key;
    logic [63:0]  b_in_block, b_out_block;

    simon_cipher_core #(.N(16), .M(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_block(a_in_block),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block), .out_mode(a_out_mode),
        .key_loaded(a_key_loaded), .busy(a_busy)
    );

    simon_cipher_core #(.N(32), .M(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_block(b_in_block),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block), .out_mode(b_out_mode),
        .key_loaded(b_key_loaded), .busy(b_busy)
    );

    localparam logic [63:0]  K32  = 64'h1918111009080100;
    localparam logic [31:0]  P32  = 32'h65656877;
    localparam logic [31:0]  C32  = 32'hc69be9bb;
    localparam logic [63:0]  KBAD = 64'hdeadbeef01234567;
    localparam logic [127:0] K64  = 128'h1b1a1918131211100b0a090803020100;
    localparam logic [63:0]  P64  = 64'h656b696c20646e75;
    localparam logic [63:0]  C64  = 64'h44c8fc20b9dfa07a;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_load_key(input logic [63:0] k, output int lat);
        a_key = k;
        a_key_valid = 1'b1;
        tick();
        a_key_valid = 1'b0;
        lat = 0;
        while (!a_key_loaded && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic a_block(input logic [31:0] blk, input logic mode,
                           output logic [31:0] res, output logic m, output int lat);
        a_in_block = blk;
        a_in_mode  = mode;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 200) begin
            tick();
            lat++;
        end
        res = a_out_block;
        m   = a_out_mode;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res, held;
        logic        m, hs;
        int          lat, n;

        rst = 1'b1;
        a_key_valid = 1'b0; a_key = '0; a_in_valid = 1'b0; a_in_mode = 1'b0;
        a_in_block = '0; a_out_ready = 1'b0;
        b_key_valid = 1'b0; b_key = '0; b_in_valid = 1'b0; b_in_mode = 1'b0;
        b_in_block = '0; b_out_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_key_ready",  64'(a_key_ready),  64'd1);
        check("rst_in_ready",   64'(a_in_ready),   64'd0);
        check("rst_out_valid",  64'(a_out_valid),  64'd0);
        check("rst_out_block",  64'(a_out_block),  64'd0);
        check("rst_out_mode",   64'(a_out_mode),   64'd0);
        check("rst_key_loaded", 64'(a_key_loaded), 64'd0);
        check("rst_busy",       64'(a_busy),       64'd0);
        rst = 1'b0;
        tick();

        // Block offered with no key is refused
        a_in_valid = 1'b1;
        #1;
        check("nokey_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        a_in_valid = 1'b0;
        check("nokey_busy", 64'(a_busy), 64'd0);

        // Arbitrary key: encrypt then decrypt must round-trip
        a_load_key(KBAD, lat);
        check("bad_key_lat", 64'(lat), 64'd32);
        a_block(P32, 1'b0, res, m, lat);
        check("bad_enc_lat", 64'(lat), 64'd32);
        a_block(res, 1'b1, res, m, lat);
        check("bad_roundtrip", 64'(res), 64'(P32));
        check("bad_dec_mode",  64'(m),   64'd1);

        // Key and block offered together: key wins, expansion window is T cycles
        a_key = K32;
        a_key_valid = 1'b1;
        a_in_block = 32'h12345678;
        a_in_valid = 1'b1;
        #1;
        check("prio_in_ready",  64'(a_in_ready),  64'd0);
        check("prio_key_ready", 64'(a_key_ready), 64'd1);
        tick();
        a_key_valid = 1'b0;
        a_in_valid  = 1'b0;
        n = 0;
        while (a_busy && n < 200) begin
            tick();
            n++;
        end
        check("prio_busy_cycles", 64'(n), 64'd32);
        check("prio_key_loaded",  64'(a_key_loaded), 64'd1);
        check("prio_no_block",    64'(a_out_valid),  64'd0);
        check("prio_idle_ready",  64'(a_in_ready),   64'd1);

        // SIMON32/64 published vector
        a_block(P32, 1'b0, res, m, lat);
        check("enc32_lat",  64'(lat), 64'd32);
        check("enc32_out",  64'(res), 64'(C32));
        check("enc32_mode", 64'(m),   64'd0);
        check("enc32_drop", 64'(a_out_valid), 64'd0);
        a_block(C32, 1'b1, res, m, lat);
        check("dec32_lat",  64'(lat), 64'd32);
        check("dec32_out",  64'(res), 64'(P32));
        check("dec32_mode", 64'(m),   64'd1);

        // Backpressure: hold output for 10 cycles with both offers pending
        a_in_block = P32;
        a_in_mode  = 1'b0;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp_lat", 64'(n), 64'd32);
        held = a_out_block;
        check("bp_out", 64'(held), 64'(C32));
        a_key_valid = 1'b1;
        a_in_block  = C32;
        a_in_mode   = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {29'd0, a_out_valid, a_in_ready, a_key_ready, a_out_block},
                             {29'd0, 1'b1, 1'b0, 1'b0, C32});
        end
        a_key_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(a_out_valid), 64'd0);
        check("bp_release_ready", 64'(a_in_ready),  64'd1);
        tick();
        check("bp_next_accept", 64'(a_busy), 64'd1);
        n = 0;
        hs = 1'b0;
        res = '0;
        m = 1'b0;
        while (!hs && n < 200) begin
            if (a_out_valid) begin
                res = a_out_block;
                m   = a_out_mode;
            end
            hs = a_in_valid && a_in_ready;
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        check("bp_period",   64'(n),   64'd34);
        check("bp_dec_out",  64'(res), 64'(P32));
        check("bp_dec_mode", 64'(m),   64'd1);
        n = 0;
        while (!a_out_valid && n < 200) begin
            tick();
            n++;
        end
        check("bp_third_lat", 64'(n), 64'd32);
        check("bp_third_out", 64'(a_out_block), 64'(P32));
        tick();
        a_out_ready = 1'b0;

        // Reset in the middle of the rounds
        a_in_block = P32;
        a_in_mode  = 1'b0;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (15) tick();
        check("mid_busy", 64'(a_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid",  64'(a_out_valid),  64'd0);
        check("mid_rst_key_loaded", 64'(a_key_loaded), 64'd0);
        check("mid_rst_in_ready",   64'(a_in_ready),   64'd0);
        check("mid_rst_key_ready",  64'(a_key_ready),  64'd1);
        check("mid_rst_out_block",  64'(a_out_block),  64'd0);
        a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_accept", {61'd0, a_in_ready, a_busy, a_out_valid}, 64'd0);
        end
        a_in_valid = 1'b0;
        a_load_key(K32, lat);
        check("reload_lat", 64'(lat), 64'd32);
        a_block(P32, 1'b0, res, m, lat);
        check("reload_enc", 64'(res), 64'(C32));

        // SIMON64/128 published vector
        b_key = K64;
        b_key_valid = 1'b1;
        tick();
        b_key_valid = 1'b0;
        n = 0;
        while (!b_key_loaded && n < 200) begin
            tick();
            n++;
        end
        check("k64_lat", 64'(n), 64'd44);
        b_in_block = P64;
        b_in_mode  = 1'b0;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 200) begin
            tick();
            n++;
        end
        check("enc64_lat", 64'(n), 64'd44);
        check("enc64_out", b_out_block, C64);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        b_in_block = C64;
        b_in_mode  = 1'b1;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 200) begin
            tick();
            n++;
        end
        check("dec64_out",  b_out_block, P64);
        check("dec64_mode", 64'(b_out_mode), 64'd1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_cipher_core.md
# simon_cipher_core

Parametrised SIMON block-cipher engine for the lightweight-cipher RPA test platform. It is the successor to the single-shot encrypt-only core, with these additions:
- a stored key schedule expanded once per key load, reused for any number of blocks;
- per-block encrypt/decrypt selection;
- valid/ready handshakes on the key, input and output channels.

It sits between the host/UART command layer and the trace-trigger logic; `busy` marks the rounds window for capture.

## Interface
- N, 16: word size in bits. Legal values are 16, 24, 32, 48, 64.
- M, 4: key words. Legal pairs are (16,4), (24,3), (24,4), (32,3), (32,4), (48,2), (48,3), (64,2), (64,3), (64,4). Any other pair stops elaboration with `$fatal`.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  key offer.
- key_ready  out  1  high in S_NOKEY and S_IDLE.
- key  in  N*M  key words {k(M-1),…,k0}; k0 sits at the LSBs.
- in_valid  in  1  block offer.
- in_ready  out  1  equals (state==S_IDLE) && !key_valid.
- in_mode  in  1  0 = encrypt, 1 = decrypt. Sampled when the block is accepted.
- in_block  in  2N  {x,y}; x is the upper N bits.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accept.
- out_block  out  2N  result {x,y}.
- out_mode  out  1  mode of the block currently on out_block.
- key_loaded  out  1  key schedule valid.
- busy  out  1  high in S_EXPAND and S_RUN.

## Operation
- T = rounds for each pair, in the legal-pair order above: 32, 36, 36, 42, 44, 52, 54, 68, 69, 72.
- z-sequence index j, same order: 0, 0, 1, 2, 3, 2, 3, 2, 3, 4. The z values are the published SIMON constants, 62 bits each.
- Rotations:
  - S^a is a rotate-left by a.
  - f(x) = (S1x & S8x) ^ S2x.
- Key schedule ks[0..T-1] is an N-bit register array with combinational read.
- Key expansion:
  - tmp = S^-3·k[i+M-1].
  - If M==4, tmp ^= k[i+1].
  - tmp ^= S^-1·tmp.
  - k[i+M] = ~k[i] ^ tmp ^ z_j[(i) mod 62] ^ 3.
- Expansion uses an M-word shift register and produces one word per cycle. ks[0..M-1] are copied directly from the key.
- Encrypt round r uses k = ks[r]: (x,y) → (y ^ f(x) ^ k, x).
- Decrypt round r uses k = ks[T-1-r]: (x,y) → (y, x ^ f(y) ^ k).
- States:
  - S_NOKEY, reset state. On a key handshake → S_EXPAND; the shift register is loaded and key_loaded drops to 0.
  - S_EXPAND. The 7-bit counter i runs 0..T-1 and writes ks[i], one per cycle. At i==T-1 → S_IDLE and key_loaded becomes 1.
  - S_IDLE:
    - A key handshake → S_EXPAND, which re-keys.
    - Otherwise a block handshake → S_RUN; the block is captured into the state register and in_mode into the mode register.
    - key_valid has priority over in_valid: in_ready is forced low while key_valid is high.
  - S_RUN. Round counter r runs 0..T-1, one round per cycle. At r==T-1 → S_OUT.
  - S_OUT:
    - out_valid is 1; out_block and out_mode are held stable.
    - On out_ready → S_IDLE.
    - key_valid and in_valid are ignored here: key_ready and in_ready are both 0.
- A block offer in S_NOKEY or S_EXPAND is not accepted, because in_ready is 0.

## Timing
- Reset values:
  - state = S_NOKEY;
  - key_ready = 1;
  - in_ready = 0;
  - out_valid = 0;
  - out_block = 0;
  - out_mode = 0;
  - key_loaded = 0;
  - busy = 0;
  - counters = 0.
- The ks contents are undefined after reset and are never read before a full expansion.
- Key load: the key handshake happens at edge e0. key_loaded = 1 and key_ready = 1 in the cycle after edge e0+T. The key path has no read of ks.
- Block latency: the handshake happens at edge a0. out_valid rises after edge a0+T.
  - Example: SIMON32/64 with T=32 gives out_valid 32 cycles after acceptance.
- Back-to-back blocks: with out_ready held at 1, the next block can be accepted one cycle after the out handshake. The period is T+2 cycles.
- out_valid stays high until out_ready is sampled 1. It drops on the edge that completes the handshake.
- rst high in any state, including mid-S_RUN or mid-S_EXPAND, returns to the reset values on the next edge. A partial result is never presented. key_loaded stays 0 until a new key is loaded.
- Counters are 7 bits wide. They never exceed T-1 (maximum 71) and do not wrap.

## Test plan
- SIMON32/64 encrypt: key=64'h1918111009080100, block 32'h65656877, mode 0 → out_block=32'hc69be9bb.
  - out_valid appears exactly 32 cycles after acceptance.
  - key_loaded rises 32 cycles after the key handshake.
- SIMON32/64 decrypt: same key, block 32'hc69be9bb, mode 1 → 32'h65656877 with out_mode=1.
- SIMON64/128 (N=32, M=4): key={1b1a1918,13121110,0b0a0908,03020100}, block 64'h656b696c20646e75 → 64'h44c8fc20b9dfa07a. Latency is 44 cycles.
- Backpressure:
  - Hold out_ready=0 for 10 cycles → out_block stays stable, in_ready=0, key_ready=0.
  - Then release → handshake happens, the next block is accepted one cycle later, and the period is 34 cycles for T=32.
- Priority and re-key:
  - In S_IDLE, assert key_valid and in_valid together → the key is taken, in_ready=0, and busy=1 for 32 cycles.
  - Then encrypt with the new key → the result matches the reference model.
- Reset mid-operation: assert rst at round 15 of S_RUN → the next cycle shows state S_NOKEY, out_valid=0, key_loaded=0, in_ready=0. A following block offer is not accepted until a key is reloaded.
